// File: rtl/sample_integrator_decim.sv
// Integrate-and-dump decimator: the integrator front half of a CIC stage, with a hold strobe to the comb.
// Optional macro SAMPLE_INTEGRATOR_RATIO_EN adds a runtime ratio input latched at start-up.
module sample_integrator_decim #(
  parameter int word_size = 8,
  parameter int DECIM     = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sample_valid,
  input  logic [word_size-1:0] Data_in,
`ifdef SAMPLE_INTEGRATOR_RATIO_EN
  input  logic [7:0]           ratio,
`endif
  output logic [word_size-1:0] Data_out,
  output logic                 hold,
  output logic                 out_valid,
  output logic [7:0]           phase
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [word_size-1:0] integ_q, integ_d;
  logic [word_size-1:0] dout_q, dout_d;
  logic [7:0]           phase_q, phase_d;
  logic                 hold_q, hold_d;
  logic                 ovalid_q, ovalid_d;
  logic [word_size-1:0] sum_s;
  logic [7:0]           last_phase_s;

`ifdef SAMPLE_INTEGRATOR_RATIO_EN
  logic [7:0] ratio_q, ratio_d;

  // Ratio is frozen for the whole run so phase never skips past the dump point
  always_comb begin
    ratio_d = ratio_q;
    if (state_q == IDLE && enable) begin
      ratio_d = (ratio < 8'd2) ? 8'd2 : ratio;
    end else begin
      ratio_d = ratio_q;
    end
  end

  // Latched ratio register
  always_ff @(posedge clock) begin
    if (reset) begin
      ratio_q <= 8'd2;
    end else begin
      ratio_q <= ratio_d;
    end
  end

  assign last_phase_s = ratio_q - 8'd1;
`else
  assign last_phase_s = 8'(DECIM - 1);
`endif

  assign sum_s = integ_q + Data_in;

  // Next-state and datapath decode
  always_comb begin
    state_d  = state_q;
    integ_d  = integ_q;
    dout_d   = dout_q;
    phase_d  = phase_q;
    hold_d   = 1'b1;
    ovalid_d = ovalid_q;
    case (state_q)
      IDLE: begin
        integ_d  = '0;
        phase_d  = 8'd0;
        ovalid_d = 1'b0;
        if (enable) begin
          state_d = PRIME;
        end else begin
          state_d = IDLE;
        end
      end
      PRIME, RUN: begin
        if (!enable) begin
          // Dropping enable discards the partial period, including a dump on this edge
          state_d  = IDLE;
          integ_d  = '0;
          phase_d  = 8'd0;
          ovalid_d = 1'b0;
        end else if (sample_valid) begin
          integ_d = sum_s;
          if (phase_q == last_phase_s) begin
            phase_d = 8'd0;
            dout_d  = sum_s;
            hold_d  = 1'b0;
            if (state_q == PRIME) begin
              state_d = RUN;
            end else begin
              ovalid_d = 1'b1;
            end
          end else begin
            phase_d = phase_q + 8'd1;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d  = IDLE;
        integ_d  = '0;
        phase_d  = 8'd0;
        ovalid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      integ_q  <= '0;
      dout_q   <= '0;
      phase_q  <= 8'd0;
      hold_q   <= 1'b1;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      integ_q  <= integ_d;
      dout_q   <= dout_d;
      phase_q  <= phase_d;
      hold_q   <= hold_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign Data_out  = dout_q;
  assign hold      = hold_q;
  assign out_valid = ovalid_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_sample_integrator_decim.sv
// Directed bench for sample_integrator_decim (word_size=8, DECIM=4): reference model plus dump scoreboard.
module tb_sample_integrator_decim;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] Data_in = 8'd0;
  logic [7:0] Data_out;
  logic       hold;
  logic       out_valid;
  logic [7:0] phase;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state, advanced once per rising edge
  logic       m_active = 1'b0;
  logic       m_run    = 1'b0;
  logic [7:0] m_integ  = 8'd0;
  logic [7:0] m_phase  = 8'd0;
  logic       exp_hold = 1'b1;
  logic       exp_ov   = 1'b0;
  logic [7:0] sb[$];
  logic [7:0] last_dout = 8'd0;
  int         n_dumps  = 0;

  always #5 clock = ~clock;

  sample_integrator_decim #(.word_size(8), .DECIM(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .sample_valid (sample_valid),
    .Data_in      (Data_in),
`ifdef SAMPLE_INTEGRATOR_RATIO_EN
    .ratio        (8'd4),
`endif
    .Data_out     (Data_out),
    .hold         (hold),
    .out_valid    (out_valid),
    .phase        (phase)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic en, input logic sv, input logic [7:0] din);
    exp_hold = 1'b1;
    if (r) begin
      m_active = 1'b0; m_run = 1'b0; m_integ = 8'd0; m_phase = 8'd0; exp_ov = 1'b0;
    end else if (!m_active) begin
      m_integ = 8'd0; m_phase = 8'd0; exp_ov = 1'b0;
      if (en) begin
        m_active = 1'b1; m_run = 1'b0;
      end
    end else if (!en) begin
      m_active = 1'b0; m_integ = 8'd0; m_phase = 8'd0; exp_ov = 1'b0;
    end else if (sv) begin
      m_integ = m_integ + din;
      if (m_phase == 8'd3) begin
        m_phase = 8'd0;
        sb.push_back(m_integ);
        exp_hold = 1'b0;
        if (m_run) exp_ov = 1'b1;
        m_run = 1'b1;
      end else begin
        m_phase = m_phase + 8'd1;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic en, input logic sv, input logic [7:0] din);
    logic [7:0] e;
    reset = r; enable = en; sample_valid = sv; Data_in = din;
    @(posedge clock);
    model(r, en, sv, din);
    #1;
    chk("hold", {7'd0, hold}, {7'd0, exp_hold});
    chk("out_valid", {7'd0, out_valid}, {7'd0, exp_ov});
    chk("phase", phase, m_phase);
    if (exp_hold == 1'b0) begin
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 8'd1, 8'd0);
      end else begin
        e = sb.pop_front();
        chk("dump_data", Data_out, e);
      end
    end
    if (hold === 1'b0) begin
      last_dout = Data_out;
      n_dumps++;
    end
  endtask

  initial begin
    // Reset state
    cyc(1'b1, 1'b0, 1'b1, 8'd9);
    cyc(1'b1, 1'b1, 1'b1, 8'd9);
    chk("reset_dout", Data_out, 8'd0);

    // Data_in=1 every cycle: dumps 4, 8, 12
    cyc(1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b1, 8'd1);
    chk("ones_last_dout", last_dout, 8'd12);
    chk("ones_dumps", 8'(n_dumps), 8'd3);

    // Data_in=100: 144 then 32 after wrap
    cyc(1'b1, 1'b0, 1'b0, 8'd0);
    cyc(1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 8'd100);
    chk("wrap_first", last_dout, 8'd144);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 8'd100);
    chk("wrap_second", last_dout, 8'd32);

    // Gapped samples of 2: one dump of 8
    cyc(1'b1, 1'b0, 1'b0, 8'd0);
    cyc(1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, (i % 2) == 0, 8'd2);
    chk("gap_dout", last_dout, 8'd8);

    // Enable drop at phase 2, then restart
    cyc(1'b1, 1'b0, 1'b0, 8'd0);
    cyc(1'b0, 1'b1, 1'b0, 8'd0);
    cyc(1'b0, 1'b1, 1'b1, 8'd3);
    cyc(1'b0, 1'b1, 1'b1, 8'd3);
    n_dumps = 0;
    cyc(1'b0, 1'b0, 1'b1, 8'd3);
    cyc(1'b0, 1'b1, 1'b0, 8'd0);
    chk("drop_no_dump", 8'(n_dumps), 8'd0);
    for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1, 1'b1, 8'(i));
    chk("restart_first", last_dout, 8'd10);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 8'd5);
    chk("restart_second", last_dout, 8'd30);

    // Reset on a dump edge with out_valid already high
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 8'd7);
    cyc(1'b1, 1'b1, 1'b1, 8'd7);
    chk("reset_dump_dout", Data_out, 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 8'd0);
    chk("sb_drained", 8'(sb.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
